instruction_fetch_unit: RTL

//  Fetch front-end sitting directly upstream of program_memory port A (consumer side of the

---
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC-driven fetch front-end with in-flight tracking and decode FIFO
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          MEM_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic [31:0] mem_addr_out,
    output logic        mem_read_out,
    input  logic [31:0] mem_instr_in,
    input  logic        mem_valid_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    input  logic        ready_in
);

    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] DEPTH_W  = 32'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;

    logic [31:0]            pc_q, pc_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW:0]            count_q, count_d;
    logic [MEM_LATENCY-1:0] trk_v_q;
    logic [MEM_LATENCY-1:0] trk_keep_q;
    logic [31:0]            trk_pc_q [MEM_LATENCY];
    logic [31:0]            fifo_instr_q [FIFO_DEPTH];
    logic [31:0]            fifo_pc_q [FIFO_DEPTH];
    logic [MEM_LATENCY-1:0] post_rst_q;

    logic [31:0] inflight;
    logic [31:0] credit_used;
    logic        issue;
    logic        fifo_wr;
    logic        fifo_rd;

    // Credit in use: FIFO occupancy plus every outstanding request, discarded or not
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + {31'b0, trk_v_q[i]};
        end
        credit_used = {{(31 - PW){1'b0}}, count_q} + inflight;
    end

    assign issue        = !rst_in && !redirect_in && (credit_used < DEPTH_W);
    assign mem_read_out = issue;
    assign mem_addr_out = pc_q;

    // The oldest tracker slot lines up with the word arriving this cycle
    assign fifo_wr   = mem_valid_in && trk_v_q[MEM_LATENCY-1] && trk_keep_q[MEM_LATENCY-1]
                       && !redirect_in;
    assign valid_out = (count_q != '0);
    assign fifo_rd   = valid_out && ready_in;
    assign instr_out = valid_out ? fifo_instr_q[rd_ptr_q] : '0;
    assign pc_out    = valid_out ? fifo_pc_q[rd_ptr_q] : '0;

    // Next PC and FIFO bookkeeping; a redirect flushes and overrides everything else
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_in) begin
            pc_d     = redirect_pc_in & 32'hFFFF_FFFC;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d = pc_q + 32'd4;
            end
            if (fifo_wr) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (fifo_rd) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // PC and FIFO control registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_q     <= START_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // In-flight tracker: one slot per memory pipeline stage; a redirect clears every keep bit
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            trk_v_q    <= '0;
            trk_keep_q <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                trk_pc_q[i] <= '0;
            end
        end else begin
            trk_v_q[0]    <= issue;
            trk_keep_q[0] <= issue;
            trk_pc_q[0]   <= pc_q;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                trk_v_q[i]    <= trk_v_q[i-1];
                trk_keep_q[i] <= trk_keep_q[i-1] && !redirect_in;
                trk_pc_q[i]   <= trk_pc_q[i-1];
            end
        end
    end

    // FIFO storage: kept responses land at the tail paired with their PC
    always_ff @(posedge clk_in) begin
        if (fifo_wr) begin
            fifo_instr_q[wr_ptr_q] <= mem_instr_in;
            fifo_pc_q[wr_ptr_q]    <= trk_pc_q[MEM_LATENCY-1];
        end
    end

    // Window after reset release in which stale responses to pre-reset requests are expected
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            post_rst_q <= '1;
        end else begin
            post_rst_q <= post_rst_q << 1;
        end
    end

    assert property (@(posedge clk_in) disable iff (rst_in || (post_rst_q != '0))
        mem_valid_in |-> trk_v_q[MEM_LATENCY-1]);

endmodule
